// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_bypass_sb                                               |
// | Purpose  : Decode-stage multi-port register file with same-cycle write     |
// |            bypass and a per-register pending-write scoreboard that stalls  |
// |            decode while a long-latency producer is still in flight.        |
// | Ports    : clk, resetn        - clock (rising edge), async active-low reset |
// |            rd_en/rd_addr      - per read port: operand used, address       |
// |            rd_data            - combinational read data (bypassed)         |
// |            wr_en/wr_addr/     - per write port: strobe, address, data,     |
// |            wr_data/wr_retire    and "completes a scoreboarded producer"    |
// |            iss_valid/iss_dst  - long-latency producer issuing at decode    |
// |            sb_flush           - discard all in-flight producers            |
// |            stall              - decode must hold this cycle                |
// |            sb_err             - one-cycle pulse on counter over/underflow  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_bypass_sb #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int CNT_W  = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   input  logic [NWR-1:0]        wr_retire,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_dst,
   input  logic                  sb_flush,
   output logic                  stall,
   output logic                  sb_err
);

   // Decrement count per register can reach NWR; the arithmetic width is
   // wide enough to hold cnt+1 and the largest decrement without wrapping.
   localparam int c_dec_w = $clog2(NWR + 1);
   localparam int c_sw    = ((CNT_W > c_dec_w) ? CNT_W : c_dec_w) + 2;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [DATA_W-1:0]  r_mem     [NREG];
   logic [CNT_W-1:0]   r_cnt     [NREG];
   logic               r_sb_err;

   logic [c_dec_w-1:0] w_dec     [NREG];
   logic [c_sw-1:0]    w_up      [NREG];
   logic [c_sw-1:0]    w_diff    [NREG];
   logic [CNT_W-1:0]   w_cnt_nxt [NREG];
   logic               w_err_any;
   logic [NRD-1:0]     w_hz;

   //--------------------------------------------------------------------------
   // Register array. Ascending port loop: the highest-index port wins when
   // several ports hit the same address. Register 0 is never written.
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
               r_mem[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
         end
      end
   end

   //--------------------------------------------------------------------------
   // Retire count per register in this cycle.
   //--------------------------------------------------------------------------
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         w_dec[r] = '0;
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_retire[w] && (wr_addr[w*AW +: AW] == AW'(r)))
               w_dec[r] = w_dec[r] + c_dec_w'(1);
         end
      end
   end

   //--------------------------------------------------------------------------
   // Read ports: bypass from the highest-index matching write port, then
   // the hazard term. A retire that drains the count this cycle clears the
   // hazard because the bypass already supplies the value.
   //--------------------------------------------------------------------------
   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]     w_addr;
      logic [DATA_W-1:0] w_val;

      assign w_addr = rd_addr[gi*AW +: AW];

      always_comb begin
         w_val = r_mem[w_addr];
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == w_addr))
               w_val = wr_data[w*DATA_W +: DATA_W];
         end
         if (w_addr == '0) w_val = '0;
      end

      assign rd_data[gi*DATA_W +: DATA_W] = w_val;
      assign w_hz[gi] = rd_en[gi] && (w_addr != '0) &&
                        (c_sw'(r_cnt[w_addr]) != c_sw'(w_dec[w_addr]));
   end

   assign stall = |w_hz;

   //--------------------------------------------------------------------------
   // Counter next state. An issue held by stall is not counted; it is
   // re-presented next cycle. Underflow clamps to 0, overflow holds at max.
   //--------------------------------------------------------------------------
   always_comb begin
      w_err_any = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         w_up[r]      = c_sw'(r_cnt[r]);
         w_diff[r]    = '0;
         w_cnt_nxt[r] = '0;
         if (r != 0) begin
            if (iss_valid && !stall && (iss_dst == AW'(r)))
               w_up[r] = w_up[r] + c_sw'(1);
            if (c_sw'(w_dec[r]) > w_up[r]) begin
               w_err_any = 1'b1;
            end else begin
               w_diff[r] = w_up[r] - c_sw'(w_dec[r]);
               if (w_diff[r] > c_sw'(c_cnt_max)) begin
                  w_cnt_nxt[r] = c_cnt_max;
                  w_err_any    = 1'b1;
               end else begin
                  w_cnt_nxt[r] = CNT_W'(w_diff[r]);
               end
            end
         end
      end
   end

   // Flush wipes every count and suppresses any error from this cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
         r_sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++)
            r_cnt[r] <= sb_flush ? '0 : w_cnt_nxt[r];
         r_sb_err <= !sb_flush && w_err_any;
      end
   end

   assign sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_bypass_sb                                            |
// | Purpose  : Scoreboard testbench for regfile_bypass_sb. A driver applies    |
// |            directed and random cycles, predicts outputs from a reference   |
// |            model and queues them; a monitor compares on the falling edge.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_regfile_bypass_sb;
   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int NR  = 32;
   localparam int MAXC = 3;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NRD-1:0]    rd_en;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic [NWR-1:0]    wr_retire;
   logic              iss_valid;
   logic [AW-1:0]     iss_dst;
   logic              sb_flush;
   logic              stall;
   logic              sb_err;

   regfile_bypass_sb dut (
      .clk(clk), .resetn(resetn),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_retire(wr_retire), .iss_valid(iss_valid), .iss_dst(iss_dst),
      .sb_flush(sb_flush), .stall(stall), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NRD*DW-1:0] rd;
      logic              st;
      logic              er;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Reference model state: architectural values, pending counts, error flag.
   logic [DW-1:0] m_mem [NR];
   int            m_cnt [NR];
   bit            m_err;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         for (int i = 0; i < NRD; i++) begin
            n_vec++;
            if (rd_data[i*DW +: DW] !== e.rd[i*DW +: DW]) begin
               n_fail++;
               $display("FAIL rd_data%0d @%0t: got %h expected %h", i, $time,
                        rd_data[i*DW +: DW], e.rd[i*DW +: DW]);
            end
         end
         n_vec++;
         if (stall !== e.st) begin
            n_fail++;
            $display("FAIL stall @%0t: got %b expected %b", $time, stall, e.st);
         end
         n_vec++;
         if (sb_err !== e.er) begin
            n_fail++;
            $display("FAIL sb_err @%0t: got %b expected %b", $time, sb_err, e.er);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic idle();
      rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      wr_retire = '0; iss_valid = 1'b0; iss_dst = '0; sb_flush = 1'b0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [DW-1:0] d, input bit ret);
      wr_en[p] = 1'b1; wr_addr[p*AW +: AW] = AW'(a); wr_data[p*DW +: DW] = d; wr_retire[p] = ret;
   endtask

   task automatic set_rd(input int p, input bit en, input int a);
      rd_en[p] = en; rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_iss(input int a);
      iss_valid = 1'b1; iss_dst = AW'(a);
   endtask

   // Predict this cycle's outputs from the current inputs, queue them,
   // advance the model across the next rising edge, then move one cycle on.
   task automatic step();
      exp_t e;
      int   d [NR];
      bit   st;
      int   a, n, inc;
      logic [DW-1:0] v;
      for (int r = 0; r < NR; r++) d[r] = 0;
      for (int w = 0; w < NWR; w++)
         if (wr_en[w] && wr_retire[w]) d[int'(wr_addr[w*AW +: AW])]++;
      st = 0;
      e.rd = '0;
      for (int i = 0; i < NRD; i++) begin
         a = int'(rd_addr[i*AW +: AW]);
         v = (a == 0) ? '0 : m_mem[a];
         if (a != 0)
            for (int w = 0; w < NWR; w++)
               if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*DW +: DW];
         e.rd[i*DW +: DW] = v;
         if (rd_en[i] && a != 0 && (m_cnt[a] - d[a]) != 0) st = 1;
      end
      e.st = st;
      e.er = m_err;
      q.push_back(e);

      if (!resetn) begin
         for (int r = 0; r < NR; r++) begin m_mem[r] = '0; m_cnt[r] = 0; end
         m_err = 0;
      end else begin
         for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] != 0)
               m_mem[int'(wr_addr[w*AW +: AW])] = wr_data[w*DW +: DW];
         m_err = 0;
         if (sb_flush) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
         end else begin
            for (int r = 1; r < NR; r++) begin
               inc = (iss_valid && !st && int'(iss_dst) == r) ? 1 : 0;
               n = m_cnt[r] + inc - d[r];
               if (n < 0)         begin n = 0;    m_err = 1; end
               else if (n > MAXC) begin n = MAXC; m_err = 1; end
               m_cnt[r] = n;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      resetn = 1'b0;
      idle();
      for (int r = 0; r < NR; r++) begin m_mem[r] = '0; m_cnt[r] = 0; end
      m_err = 0;
      @(posedge clk); #1;
      repeat (3) step();
      resetn = 1'b1;
      step();

      // same-cycle write bypass, then persistent value
      idle(); set_wr(0, 5, 32'hDEADBEEF, 0); set_rd(0, 1, 5); step();
      idle(); set_rd(0, 1, 5); step(); step();

      // register 0 ignores writes and issues
      idle(); set_wr(1, 0, 32'h1234, 0); set_rd(0, 1, 0); set_rd(1, 1, 0); step();
      idle(); set_iss(0); set_rd(0, 1, 0); step();
      idle(); set_rd(0, 1, 0); step();

      // two ports to one address: highest port wins
      idle(); set_wr(0, 7, 32'h11, 0); set_wr(1, 7, 32'h22, 0); set_rd(0, 1, 7); step();
      idle(); set_rd(0, 1, 7); step();

      // load-use with operand used
      idle(); set_iss(9); step();
      repeat (3) begin idle(); set_rd(0, 1, 9); step(); end
      idle(); set_rd(0, 1, 9); set_wr(0, 9, 32'hA5, 1); step();
      idle(); set_rd(0, 1, 9); step();

      // load-use with operand unused
      idle(); set_iss(9); step();
      repeat (2) begin idle(); set_rd(0, 0, 9); step(); end
      idle(); set_rd(0, 0, 9); set_wr(0, 9, 32'h5A, 1); step();

      // two producers to r3
      idle(); set_iss(3); step();
      idle(); set_iss(3); step();
      idle(); set_rd(0, 1, 3); step();
      idle(); set_rd(0, 1, 3); set_wr(0, 3, 32'h31, 1); step();
      idle(); set_rd(0, 1, 3); step();
      idle(); set_rd(0, 1, 3); set_wr(1, 3, 32'h32, 1); step();
      idle(); set_rd(0, 1, 3); step();

      // overflow on r4, flush, then underflow
      repeat (4) begin idle(); set_iss(4); step(); end
      idle(); step(); step();
      idle(); sb_flush = 1'b1; set_rd(0, 1, 4); step();
      idle(); set_rd(0, 1, 4); step();
      idle(); set_wr(0, 4, 32'h44, 1); step();
      idle(); step(); step();

      // random traffic concentrated on a few registers to provoke hazards
      for (int k = 0; k < 1500; k++) begin
         idle();
         for (int w = 0; w < NWR; w++) begin
            if ($urandom_range(0, 2) == 0) begin
               int a;
               a = $urandom_range(0, 7);
               set_wr(w, a, $urandom, (a != 0) && ($urandom_range(0, 1) == 1));
            end
         end
         for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 1) == 1, $urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) set_iss($urandom_range(0, 7));
         sb_flush = ($urandom_range(0, 39) == 0);
         step();
      end
      idle(); repeat (3) step();

      repeat (4) @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
